fft_bitrev_reorder: RTL

Output reorder stage for the FFT datapath. The FFT core writes complex results in bit-reversed order; this block buffers each N-point frame and re-emits it in natural index order over a valid/ready stream. It uses a ping-pong pair of frame buffers, so one frame is written while the previous one is read. Samples use the shared Q16.16 `Complex` format (Re, Im; each `DATA_WIDTH` signed).

---
 rtl/complex_type.sv | 23 ++
 rtl/fft_bitrev_reorder_if.sv | 28 ++
 rtl/fft_frame_bank.sv | 25 ++
 rtl/fft_bitrev_reorder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/complex_type.sv
// Shared Q16.16 complex sample type and bit-reverse helper for the FFT datapath.
package complex_type;

   localparam int unsigned DATA_WIDTH = 32;

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] re;
      logic signed [DATA_WIDTH-1:0] im;
   } Complex;

   // Reverse the low 'width' bits of 'index'; bits above 'width' are ignored.
   function automatic int unsigned bitrev(input int unsigned index, input int unsigned width);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) begin
            res = (res << 1) | ((index >> i) & 32'd1);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Input and output streams of the bit-reverse reorder stage.
interface fft_bitrev_reorder_if #(
   parameter int unsigned N_POINTS = 8
);
   import complex_type::*;

   localparam int unsigned IdxW = $clog2(N_POINTS);

   logic                    in_valid;
   logic                    in_ready;
   logic [2*DATA_WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*DATA_WIDTH-1:0] out_data;
   logic [IdxW-1:0]         out_index;
   logic                    out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );

endinterface

// File: rtl/fft_frame_bank.sv
// One N-point frame buffer: a single write port and a combinational read port.
module fft_frame_bank
   import complex_type::*;
#(
   parameter int unsigned N_POINTS = 8
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [$clog2(N_POINTS)-1:0] waddr,
   input  Complex                      wdata,
   input  logic [$clog2(N_POINTS)-1:0] raddr,
   output Complex                      rdata
);

   Complex mem [N_POINTS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed FFT frames into natural order.
// Optional 1/N output scaling is enabled with FFT_REORDER_SCALE_EN.
module fft_bitrev_reorder
   import complex_type::*;
#(
   parameter int unsigned N_POINTS = 8
) (
   input logic                clk,
   input logic                rst,
   fft_bitrev_reorder_if.slave bus
);

   localparam int unsigned     IdxW    = $clog2(N_POINTS);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_POINTS - 1);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StStream = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [1:0]      full_q, full_d;
   logic            wr_bank_q;
   logic            rd_bank_q, rd_bank_d;
   logic [IdxW-1:0] wr_cnt_q;
   logic [IdxW-1:0] rd_cnt_q, rd_cnt_d;

   logic            out_valid_q, out_valid_d;
   Complex          out_data_q;
   logic [IdxW-1:0] out_index_q;
   logic            out_last_q;

   logic            in_ready;
   logic            in_fire, out_fire;
   logic            wr_done, rd_done;
   logic            load, rd_sel;
   logic [IdxW-1:0] wr_addr, rd_addr;
   logic [1:0]      bank_we;
   Complex          in_sample, rdata0, rdata1, rd_sample, scaled;

   // Write side
   assign in_ready  = ~full_q[wr_bank_q];
   assign in_fire   = bus.in_valid & in_ready;
   assign wr_done   = in_fire && (wr_cnt_q == LastIdx);
   assign wr_addr   = IdxW'(bitrev(32'(wr_cnt_q), IdxW));
   assign in_sample = bus.in_data;
   assign bank_we   = {in_fire & wr_bank_q, in_fire & ~wr_bank_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
      end else if (in_fire) begin
         wr_cnt_q <= wr_done ? '0 : wr_cnt_q + 1'b1;
         if (wr_done) begin
            wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   fft_frame_bank #(
      .N_POINTS (N_POINTS)
   ) u_bank0 (
      .clk   (clk),
      .we    (bank_we[0]),
      .waddr (wr_addr),
      .wdata (in_sample),
      .raddr (rd_addr),
      .rdata (rdata0)
   );

   fft_frame_bank #(
      .N_POINTS (N_POINTS)
   ) u_bank1 (
      .clk   (clk),
      .we    (bank_we[1]),
      .waddr (wr_addr),
      .wdata (in_sample),
      .raddr (rd_addr),
      .rdata (rdata1)
   );

   assign rd_sample = rd_sel ? rdata1 : rdata0;

`ifdef FFT_REORDER_SCALE_EN
   always_comb begin
      scaled    = rd_sample;
      scaled.re = $signed(rd_sample.re) >>> IdxW;
      scaled.im = $signed(rd_sample.im) >>> IdxW;
   end
`else
   assign scaled = rd_sample;
`endif

   // Read side. A frame completing this cycle is picked up directly from wr_done so the
   // first output appears one cycle after the last input and frames chain without a bubble.
   assign out_fire = out_valid_q & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      rd_sel      = rd_bank_q;
      rd_addr     = '0;
      load        = 1'b0;
      rd_done     = 1'b0;
      case (state_q)
         StIdle: begin
            if (full_q[rd_bank_q] || (wr_done && (wr_bank_q == rd_bank_q))) begin
               load        = 1'b1;
               out_valid_d = 1'b1;
               rd_cnt_d    = '0;
               state_d     = StStream;
            end
         end
         StStream: begin
            if (out_fire) begin
               if (rd_cnt_q == LastIdx) begin
                  rd_done   = 1'b1;
                  rd_bank_d = ~rd_bank_q;
                  rd_cnt_d  = '0;
                  if (full_q[~rd_bank_q] || (wr_done && (wr_bank_q != rd_bank_q))) begin
                     load   = 1'b1;
                     rd_sel = ~rd_bank_q;
                  end else begin
                     out_valid_d = 1'b0;
                     state_d     = StIdle;
                  end
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
                  rd_addr  = rd_cnt_q + 1'b1;
                  load     = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // The drained and the filled bank are always different, so both updates apply.
   always_comb begin
      full_d = full_q;
      if (rd_done) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (wr_done) begin
         full_d[wr_bank_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         full_q    <= '0;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (load) begin
            out_data_q  <= scaled;
            out_index_q <= rd_addr;
            out_last_q  <= (rd_addr == LastIdx);
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_index = out_index_q;
   assign bus.out_last  = out_last_q;

   hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q)
                                            && $stable(out_index_q)));

   distinct_banks: assert property (@(posedge clk) disable iff (rst)
      !(rd_done && wr_done && (rd_bank_q == wr_bank_q)));

endmodule
